// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one column at a time, debounces the
// press and the release of a single key, and reports the accepted key as a
// hex code with a one-cycle strobe.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// SCAN       | sweep columns, sample rows at the end of each column slot
// PRESS_DB   | column frozen, waiting for the row code to stay stable
// HELD       | key accepted, waiting for the latched row to go high
// RELEASE_DB | column frozen, waiting for the latched row to stay high
//
// Ports
//   int_osc  in   system clock, all state on its rising edge
//   reset    in   asynchronous active-low reset
//   rows     in   [3:0] keypad rows, active-low, asynchronous to int_osc
//   cols     out  [3:0] column drives, exactly one bit low
//   key      out  [3:0] hex code of the last accepted key
//   keyValid out  one-cycle strobe when a key is accepted
//   keyHeld  out  high from acceptance until the release is debounced
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000,
    parameter int CNT_BITS        = 20
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       keyValid,
    output logic       keyHeld
);

    localparam logic [1:0] ST_SCAN       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    localparam logic [CNT_BITS-1:0] SLOT_LAST = CNT_BITS'(SCAN_DIV - 1);
    localparam logic [CNT_BITS-1:0] DB_LAST   = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

    logic [3:0]          rows_meta_q;
    logic [3:0]          rows_s_q;

    logic [1:0]          state_q,     state_d;
    logic [1:0]          col_idx_q,   col_idx_d;
    logic [CNT_BITS-1:0] slot_cnt_q,  slot_cnt_d;
    logic [CNT_BITS-1:0] db_cnt_q,    db_cnt_d;
    logic [3:0]          row_code_q,  row_code_d;
    logic [1:0]          row_idx_q,   row_idx_d;
    logic [3:0]          key_q,       key_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q,  key_held_d;

    logic                press_valid;
    logic [1:0]          press_row;
    logic                rows_match;
    logic                row_released;

    // Row code of the key at row r, column c.
    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer; idle (pulled-up) value out of reset.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            rows_meta_q <= 4'hF;
            rows_s_q    <= 4'hF;
        end else begin
            rows_meta_q <= rows;
            rows_s_q    <= rows_meta_q;
        end
    end

    // Only a single low row counts as a press; multi-row patterns are
    // ambiguous and treated as nothing pressed.
    always_comb begin
        press_valid = 1'b0;
        press_row   = 2'd0;
        case (rows_s_q)
            4'b1110: begin press_valid = 1'b1; press_row = 2'd0; end
            4'b1101: begin press_valid = 1'b1; press_row = 2'd1; end
            4'b1011: begin press_valid = 1'b1; press_row = 2'd2; end
            4'b0111: begin press_valid = 1'b1; press_row = 2'd3; end
            default: begin press_valid = 1'b0; press_row = 2'd0; end
        endcase
    end

    assign rows_match   = (rows_s_q == row_code_q);
    // Once held, only the latched row matters; other rows going low are ignored.
    assign row_released = rows_s_q[row_idx_q];

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        slot_cnt_d  = slot_cnt_q;
        db_cnt_d    = db_cnt_q;
        row_code_d  = row_code_q;
        row_idx_d   = row_idx_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            ST_SCAN: begin
                if (slot_cnt_q == SLOT_LAST) begin
                    slot_cnt_d = '0;
                    if (press_valid) begin
                        row_code_d = rows_s_q;
                        row_idx_d  = press_row;
                        db_cnt_d   = '0;
                        state_d    = ST_PRESS_DB;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + CNT_ONE;
                end
            end

            ST_PRESS_DB: begin
                if (!rows_match) begin
                    state_d    = ST_SCAN;
                    col_idx_d  = col_idx_q + 2'd1;
                    slot_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    key_d       = map_key(row_idx_q, col_idx_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end

            ST_HELD: begin
                if (row_released) begin
                    db_cnt_d = '0;
                    state_d  = ST_RELEASE_DB;
                end
            end

            ST_RELEASE_DB: begin
                if (!row_released) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = ST_SCAN;
                    key_held_d = 1'b0;
                    col_idx_d  = col_idx_q + 2'd1;
                    slot_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            slot_cnt_q  <= '0;
            db_cnt_q    <= '0;
            row_code_q  <= 4'hF;
            row_idx_q   <= 2'd0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            slot_cnt_q  <= slot_cnt_d;
            db_cnt_q    <= db_cnt_d;
            row_code_q  <= row_code_d;
            row_idx_q   <= row_idx_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign cols     = ~(4'b0001 << col_idx_q);
    assign key      = key_q;
    assign keyValid = key_valid_q;
    assign keyHeld  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A small keypad model pulls a row low whenever a pressed key sits in the
// column currently driven low. Edge numbers in the tasks count rising edges
// after reset release; rows seen by the FSM on edge k were driven before
// edge k-2 (two-flop synchronizer).
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int CNT_BITS        = 20;

    logic        int_osc = 1'b0;
    logic        reset   = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        keyValid;
    logic        keyHeld;

    // bit r*4+c set = key at row r, column c is closed
    logic [15:0] pressed = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .int_osc(int_osc),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .key(key),
        .keyValid(keyValid),
        .keyHeld(keyHeld)
    );

    always #5 int_osc = ~int_osc;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    // Expected column drive after n edges of free scanning from reset.
    function automatic logic [3:0] exp_cols(input int n);
        int idx;
        idx = (n / SCAN_DIV) % 4;
        return ~(4'b0001 << idx);
    endfunction

    task automatic tick();
        @(posedge int_osc);
        #1;
    endtask

    // Reset with the given keys closed; returns 1 time unit after an edge,
    // so the next rising edge is edge 1.
    task automatic start(input logic [15:0] keys);
        reset   = 1'b0;
        pressed = keys;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int cnt;
        start(16'h0000);
        repeat (6) tick();
        n_checks++;
        if (cols !== 4'b1101) begin
            n_fail++; $display("FAIL reset_prescan_cols: got %b expected 1101", cols);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (cols !== 4'b1110) begin
            n_fail++; $display("FAIL reset_cols: got %b expected 1110", cols);
        end
        n_checks++;
        if (key !== 4'h0) begin
            n_fail++; $display("FAIL reset_key: got %h expected 0", key);
        end
        n_checks++;
        if (keyValid !== 1'b0) begin
            n_fail++; $display("FAIL reset_keyValid: got %b expected 0", keyValid);
        end
        n_checks++;
        if (keyHeld !== 1'b0) begin
            n_fail++; $display("FAIL reset_keyHeld: got %b expected 0", keyHeld);
        end
        tick();
        reset = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            n_checks++;
            if (cols !== exp_cols(n)) begin
                n_fail++; $display("FAIL reset_sweep edge %0d: got %b expected %b", n, cols, exp_cols(n));
            end
        end

        // reset in the middle of a press debounce abandons it
        start(16'h0001);
        repeat (8) tick();
        reset   = 1'b0;
        pressed = 16'h0000;
        tick();
        reset = 1'b1;
        cnt   = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (keyValid) cnt++;
        end
        n_checks++;
        if (cnt !== 0) begin
            n_fail++; $display("FAIL reset_midpress_strobes: got %0d expected 0", cnt);
        end
        n_checks++;
        if (keyHeld !== 1'b0) begin
            n_fail++; $display("FAIL reset_midpress_keyHeld: got %b expected 0", keyHeld);
        end
    endtask

    task automatic wait_release(input string name);
        int t;
        pressed = 16'h0000;
        t = 0;
        while (keyHeld && t < 40) begin
            tick();
            t++;
        end
        n_checks++;
        if (keyHeld !== 1'b0) begin
            n_fail++; $display("FAIL %s_release_timeout: keyHeld got %b expected 0", name, keyHeld);
        end
    endtask

    task automatic test_clean_press();
        int cnt, first;
        cnt = 0; first = 0;
        start(16'h0040);   // r1/c2
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 19) begin
                n_checks++;
                if (keyHeld !== 1'b0) begin
                    n_fail++; $display("FAIL clean_held_early: got %b expected 0", keyHeld);
                end
            end
            if (keyValid) begin
                cnt++;
                if (first == 0) first = n;
                n_checks++;
                if (keyHeld !== 1'b1) begin
                    n_fail++; $display("FAIL clean_held_with_strobe: got %b expected 1", keyHeld);
                end
            end
        end
        n_checks++;
        if (first !== 20) begin
            n_fail++; $display("FAIL clean_strobe_edge: got %0d expected 20", first);
        end
        n_checks++;
        if (cnt !== 1) begin
            n_fail++; $display("FAIL clean_strobe_count: got %0d expected 1", cnt);
        end
        n_checks++;
        if (key !== 4'h6) begin
            n_fail++; $display("FAIL clean_key: got %h expected 6", key);
        end
        n_checks++;
        if (keyHeld !== 1'b1) begin
            n_fail++; $display("FAIL clean_keyHeld: got %b expected 1", keyHeld);
        end
        n_checks++;
        if (cols !== 4'b1011) begin
            n_fail++; $display("FAIL clean_cols_frozen: got %b expected 1011", cols);
        end
        wait_release("clean");
        n_checks++;
        if (key !== 4'h6) begin
            n_fail++; $display("FAIL clean_key_after_release: got %h expected 6", key);
        end
    endtask

    task automatic test_press_bounce();
        int cnt, first;
        cnt = 0; first = 0;
        start(16'h0000);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 4)  pressed = 16'h2000;   // r3/c1 closes as c1 is driven
            if (n == 9)  pressed = 16'h0000;   // one-cycle bounce
            if (n == 10) pressed = 16'h2000;
            if (keyValid) begin
                cnt++;
                if (first == 0) first = n;
            end
        end
        n_checks++;
        if (first !== 36) begin
            n_fail++; $display("FAIL bounce_strobe_edge: got %0d expected 36", first);
        end
        n_checks++;
        if (cnt !== 1) begin
            n_fail++; $display("FAIL bounce_strobe_count: got %0d expected 1", cnt);
        end
        n_checks++;
        if (key !== 4'h0) begin
            n_fail++; $display("FAIL bounce_key: got %h expected 0", key);
        end
        n_checks++;
        if (cols !== 4'b1101) begin
            n_fail++; $display("FAIL bounce_cols: got %b expected 1101", cols);
        end
        wait_release("bounce");
    endtask

    task automatic test_held_second_key();
        int cnt, first, second;
        cnt = 0; first = 0; second = 0;
        start(16'h0001);   // r0/c0
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (n == 12) pressed = 16'h0801;   // add r2/c3 while r0/c0 is held
            if (n == 40) pressed = 16'h0800;   // release r0/c0
            if (keyValid) begin
                cnt++;
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
            if (n == 12) begin
                n_checks++;
                if (key !== 4'h1) begin
                    n_fail++; $display("FAIL held_first_key: got %h expected 1", key);
                end
            end
            if (n == 39) begin
                n_checks++;
                if (key !== 4'h1) begin
                    n_fail++; $display("FAIL held_key_kept: got %h expected 1", key);
                end
                n_checks++;
                if (cols !== 4'b1110) begin
                    n_fail++; $display("FAIL held_cols: got %b expected 1110", cols);
                end
            end
            if (n == 50) begin
                n_checks++;
                if (keyHeld !== 1'b1) begin
                    n_fail++; $display("FAIL held_release_early: got %b expected 1", keyHeld);
                end
            end
            if (n == 51) begin
                n_checks++;
                if (keyHeld !== 1'b0) begin
                    n_fail++; $display("FAIL held_release_done: got %b expected 0", keyHeld);
                end
            end
        end
        n_checks++;
        if (first !== 12) begin
            n_fail++; $display("FAIL held_first_edge: got %0d expected 12", first);
        end
        n_checks++;
        if (second !== 71) begin
            n_fail++; $display("FAIL held_second_edge: got %0d expected 71", second);
        end
        n_checks++;
        if (cnt !== 2) begin
            n_fail++; $display("FAIL held_strobe_count: got %0d expected 2", cnt);
        end
        n_checks++;
        if (key !== 4'hC) begin
            n_fail++; $display("FAIL held_second_key: got %h expected C", key);
        end
        n_checks++;
        if (cols !== 4'b0111) begin
            n_fail++; $display("FAIL held_second_cols: got %b expected 0111", cols);
        end
        wait_release("held");
    endtask

    task automatic test_release_bounce();
        int cnt;
        logic exp_held;
        cnt = 0;
        start(16'h0001);   // r0/c0, accepted on edge 12
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (n == 14) pressed = 16'h0000;   // high 3
            if (n == 17) pressed = 16'h0001;   // low 2
            if (n == 19) pressed = 16'h0000;   // high for good
            if (keyValid) cnt++;
            exp_held = (n >= 12 && n <= 29);
            n_checks++;
            if (keyHeld !== exp_held) begin
                n_fail++; $display("FAIL relbounce_keyHeld edge %0d: got %b expected %b", n, keyHeld, exp_held);
            end
        end
        n_checks++;
        if (cnt !== 1) begin
            n_fail++; $display("FAIL relbounce_strobe_count: got %0d expected 1", cnt);
        end
        n_checks++;
        if (key !== 4'h1) begin
            n_fail++; $display("FAIL relbounce_key: got %h expected 1", key);
        end
    endtask

    task automatic test_multi_row();
        int cnt;
        cnt = 0;
        start(16'h0011);   // r0/c0 and r1/c0
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (keyValid) cnt++;
            n_checks++;
            if (cols !== exp_cols(n)) begin
                n_fail++; $display("FAIL multirow_cols edge %0d: got %b expected %b", n, cols, exp_cols(n));
            end
        end
        n_checks++;
        if (cnt !== 0) begin
            n_fail++; $display("FAIL multirow_strobes: got %0d expected 0", cnt);
        end
        n_checks++;
        if (keyHeld !== 1'b0) begin
            n_fail++; $display("FAIL multirow_keyHeld: got %b expected 0", keyHeld);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_held_second_key();
        test_release_bounce();
        test_multi_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
